// File: rtl/oam_dma.sv
// OAM DMA engine: snoops the FF46 write and copies OAM_BYTES bytes from page
// SRC_HI into OAM at FE00, one byte every BYTE_CYCLES clocks.
module oam_dma #(
    parameter int BYTE_CYCLES = 4,
    parameter int START_DELAY = 4,
    parameter int OAM_BYTES   = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ADDR,
    input  logic        WR,
    input  logic [7:0]  MMIO_DATA_out,
    output logic        DMA_ACTIVE,
    output logic        DMA_RD,
    output logic [15:0] DMA_ADDR,
    input  logic [7:0]  DMA_DATA_in,
    output logic        OAM_WR,
    output logic [15:0] OAM_ADDR,
    output logic [7:0]  OAM_DATA_out
);

    localparam int PW = $clog2(BYTE_CYCLES);
    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(BYTE_CYCLES - 1);
    localparam logic [DW-1:0] DELAY_LOAD = (START_DELAY > 0) ? DW'(START_DELAY - 1) : '0;
    localparam logic [7:0]    LAST_IDX   = 8'(OAM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    src_hi_reg, src_hi_next;
    logic [7:0]    idx_reg, idx_next;
    logic [PW-1:0] phase_reg, phase_next;
    logic [DW-1:0] delay_reg, delay_next;

    logic          dma_active_reg;
    logic          dma_rd_reg;
    logic [15:0]   dma_addr_reg;
    logic          oam_wr_reg;
    logic [15:0]   oam_addr_reg;
    logic [7:0]    oam_data_hold_reg;

    logic          trigger;
    logic [7:0]    src_mapped;
    logic          rd_next;
    logic          wr_next;

    assign trigger = WR && (ADDR == 16'hFF46);
    // Pages E0..FF are echo RAM; fold them back onto C0..DF.
    assign src_mapped = (MMIO_DATA_out > 8'hDF) ? (MMIO_DATA_out - 8'h20) : MMIO_DATA_out;

    always_comb begin
        state_next  = state_reg;
        src_hi_next = src_hi_reg;
        idx_next    = idx_reg;
        phase_next  = phase_reg;
        delay_next  = delay_reg;

        case (state_reg)
            IDLE: begin
            end
            START: begin
                if (delay_reg == '0) begin
                    state_next = XFER;
                    phase_next = '0;
                    idx_next   = 8'h00;
                end else begin
                    delay_next = delay_reg - DW'(1);
                end
            end
            XFER: begin
                // The copy ends right after the last OAM write, not at the end of its slot.
                if (phase_reg == PW'(1) && idx_reg == LAST_IDX) begin
                    state_next = IDLE;
                    phase_next = '0;
                    idx_next   = 8'h00;
                end else if (phase_reg == LAST_PHASE) begin
                    phase_next = '0;
                    idx_next   = idx_reg + 8'h01;
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
                idx_next   = 8'h00;
            end
        endcase

        // A trigger overrides everything, including an in-flight copy.
        if (trigger) begin
            src_hi_next = src_mapped;
            idx_next    = 8'h00;
            phase_next  = '0;
            delay_next  = DELAY_LOAD;
            state_next  = (START_DELAY == 0) ? XFER : START;
        end
    end

    assign rd_next = (state_next == XFER) && (phase_next == '0);
    assign wr_next = (state_next == XFER) && (phase_next == PW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            src_hi_reg        <= 8'h00;
            idx_reg           <= 8'h00;
            phase_reg         <= '0;
            delay_reg         <= '0;
            dma_active_reg    <= 1'b0;
            dma_rd_reg        <= 1'b0;
            dma_addr_reg      <= 16'h0000;
            oam_wr_reg        <= 1'b0;
            oam_addr_reg      <= 16'h0000;
            oam_data_hold_reg <= 8'h00;
        end else begin
            state_reg      <= state_next;
            src_hi_reg     <= src_hi_next;
            idx_reg        <= idx_next;
            phase_reg      <= phase_next;
            delay_reg      <= delay_next;
            dma_active_reg <= (state_next != IDLE);
            dma_rd_reg     <= rd_next;
            oam_wr_reg     <= wr_next;
            if (rd_next) begin
                dma_addr_reg <= {src_hi_next, idx_next};
            end
            if (wr_next) begin
                oam_addr_reg <= 16'hFE00 + {8'h00, idx_next};
            end
            if (oam_wr_reg) begin
                oam_data_hold_reg <= DMA_DATA_in;
            end
        end
    end

    assign DMA_ACTIVE   = dma_active_reg;
    assign DMA_RD       = dma_rd_reg;
    assign DMA_ADDR     = dma_addr_reg;
    assign OAM_WR       = oam_wr_reg;
    assign OAM_ADDR     = oam_addr_reg;
    // Source data arrives the clock after the read, so it is forwarded straight through.
    assign OAM_DATA_out = oam_wr_reg ? DMA_DATA_in : oam_data_hold_reg;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: two instances (default timing and the fast
// BYTE_CYCLES=2/START_DELAY=0 corner) share one CPU bus and a source memory.
`timescale 1ns/1ps
module tb_oam_dma;

    typedef struct {
        int         cyc;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        wr = 1'b0;
    logic [7:0]  wdata = 8'h00;

    logic [1:0]  dma_active;
    logic [1:0]  dma_rd;
    logic [1:0]  oam_wr;
    logic [15:0] dma_addr [2];
    logic [15:0] oam_addr [2];
    logic [7:0]  oam_data [2];

    logic [7:0]  mem [0:65535];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Posedge of cycle n is at 10n+5; the following negedge belongs to the same cycle.
    function automatic int cycnow();
        return int'(($time - 5) / 10);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cycnow());
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int BC = (gi == 0) ? 4 : 2;
        localparam int SD = (gi == 0) ? 4 : 0;

        logic [7:0] rdata;
        ev_t rdq[$];
        ev_t wrq[$];
        int  act_lo = 0;
        int  act_hi = -1;

        oam_dma #(.BYTE_CYCLES(BC), .START_DELAY(SD), .OAM_BYTES(160)) dut (
            .clk          (clk),
            .rst          (rst),
            .ADDR         (addr),
            .WR           (wr),
            .MMIO_DATA_out(wdata),
            .DMA_ACTIVE   (dma_active[gi]),
            .DMA_RD       (dma_rd[gi]),
            .DMA_ADDR     (dma_addr[gi]),
            .DMA_DATA_in  (rdata),
            .OAM_WR       (oam_wr[gi]),
            .OAM_ADDR     (oam_addr[gi]),
            .OAM_DATA_out (oam_data[gi])
        );

        always @(posedge clk) begin
            if (dma_rd[gi]) rdata <= mem[dma_addr[gi]];
        end

        // Reference model: a trigger in cycle t schedules the whole copy as absolute-cycle events.
        always @(posedge clk) begin
            int t;
            logic [7:0] hi;
            ev_t e;
            if (!rst && wr && addr == 16'hFF46) begin
                t  = cycnow() - 1;
                hi = (wdata >= 8'hE0) ? wdata - 8'h20 : wdata;
                while (rdq.size() > 0 && rdq[rdq.size()-1].cyc > t) void'(rdq.pop_back());
                while (wrq.size() > 0 && wrq[wrq.size()-1].cyc > t) void'(wrq.pop_back());
                for (int i = 0; i < 160; i++) begin
                    e.cyc  = t + 1 + SD + i * BC;
                    e.addr = {hi, 8'(i)};
                    e.data = 8'h00;
                    rdq.push_back(e);
                    e.cyc  = t + 2 + SD + i * BC;
                    e.data = mem[{hi, 8'(i)}];
                    e.addr = 16'hFE00 + 16'(i);
                    wrq.push_back(e);
                end
                act_lo = t;
                act_hi = t + 2 + SD + 159 * BC;
            end
        end

        always @(posedge rst) begin
            rdq.delete();
            wrq.delete();
            act_hi = -1;
        end

        always @(negedge clk) begin
            int   c;
            logic exp_rd, exp_wr;
            ev_t  e;
            if (!rst) begin
                c = cycnow();
                chk($sformatf("i%0d_active", gi), dma_active[gi],
                    (act_hi >= 0 && c > act_lo && c <= act_hi));
                while (rdq.size() > 0 && rdq[0].cyc < c) begin
                    chk($sformatf("i%0d_rd_missed", gi), c, rdq[0].cyc);
                    void'(rdq.pop_front());
                end
                while (wrq.size() > 0 && wrq[0].cyc < c) begin
                    chk($sformatf("i%0d_wr_missed", gi), c, wrq[0].cyc);
                    void'(wrq.pop_front());
                end
                exp_rd = (rdq.size() > 0 && rdq[0].cyc == c);
                exp_wr = (wrq.size() > 0 && wrq[0].cyc == c);
                chk($sformatf("i%0d_dma_rd", gi), dma_rd[gi], exp_rd);
                chk($sformatf("i%0d_oam_wr", gi), oam_wr[gi], exp_wr);
                if (dma_rd[gi] && exp_rd) begin
                    e = rdq.pop_front();
                    chk($sformatf("i%0d_dma_addr", gi), dma_addr[gi], e.addr);
                end
                if (oam_wr[gi] && exp_wr) begin
                    e = wrq.pop_front();
                    chk($sformatf("i%0d_oam_addr", gi), oam_addr[gi], e.addr);
                    chk($sformatf("i%0d_oam_data", gi), oam_data[gi], e.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        $display("write cycle=%0d addr=%04h data=%02h", cycnow(), a, d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        tick(1);
        wr    = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (dma_active != 2'b00 && k < 2000) begin
            tick(1);
            k++;
        end
        chk("drain_timeout", (k < 2000), 1);
        tick(3);
    endtask

    initial begin
        int n;
        int k;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 160; i++) mem[16'hC000 + i] = 8'hA5 ^ 8'(i);

        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_active", dma_active[i], 0);
            chk("rst_dma_rd", dma_rd[i], 0);
            chk("rst_oam_wr", oam_wr[i], 0);
            chk("rst_dma_addr", dma_addr[i], 0);
            chk("rst_oam_addr", oam_addr[i], 0);
            chk("rst_oam_data", oam_data[i], 0);
        end
        rst = 1'b0;
        tick(2);

        // Writes that must not start a copy.
        bus_write(16'hFF45, 8'hC0);
        bus_write(16'hFF47, 8'hC0);
        bus_write(16'hFE00, 8'h12);
        tick(10);

        bus_write(16'hFF46, 8'hC0);
        drain();
        bus_write(16'hFF46, 8'hE3);
        drain();
        bus_write(16'hFF46, 8'hFF);
        drain();

        // Restart after 50 bytes of the slow instance.
        bus_write(16'hFF46, 8'h80);
        n = 0;
        k = 0;
        while (n < 50 && k < 1000) begin
            @(negedge clk);
            if (oam_wr[0]) n++;
            k++;
        end
        chk("restart_wait_timeout", (k < 1000), 1);
        @(posedge clk);
        #1;
        bus_write(16'hFF46, 8'hC1);
        drain();

        // Trigger coinciding with the final OAM write of the slow instance.
        bus_write(16'hFF46, 8'h42);
        tick(641);
        bus_write(16'hFF46, 8'h55);
        drain();

        // Asynchronous reset mid-transfer, between clock edges.
        bus_write(16'hFF46, 8'hC0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!dma_rd[0] && k < 1000);
        chk("reset_wait_timeout", (k < 1000), 1);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst_active", dma_active[i], 0);
            chk("arst_dma_rd", dma_rd[i], 0);
            chk("arst_oam_wr", oam_wr[i], 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        tick(40);
        bus_write(16'hFF46, 8'hC2);
        drain();

        // Randomized triggers, restarts and unrelated register writes.
        for (int r = 0; r < 8; r++) begin
            logic [7:0] lo;
            lo = 8'($urandom_range(0, 255));
            if (lo != 8'h46) bus_write({8'hFF, lo}, 8'($urandom));
            bus_write(16'hFF46, 8'($urandom));
            tick($urandom_range(0, 700));
        end
        drain();

        chk("i0_rdq_empty", g[0].rdq.size(), 0);
        chk("i0_wrq_empty", g[0].wrq.size(), 0);
        chk("i1_rdq_empty", g[1].rdq.size(), 0);
        chk("i1_wrq_empty", g[1].wrq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
